// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter/sequencer (IDLE/ACCESS/RESP)
// Optional round-robin tie-breaking enabled by defining MEM_ARB_RR_EN; default is data-priority.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  f_req_i,
  input  logic [ADDR_WIDTH-1:0] f_addr_i,
  output logic                  f_ack_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wd_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic                  owner_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  we_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  f_ack_q;
  logic                  d_ack_q;
  logic                  mem_we_q;
  logic                  mem_re_q;
  logic                  grant_data_d;

`ifdef MEM_ARB_RR_EN
  // rr_q remembers the last owner; a tie goes to the other requester.
  logic rr_q;
  assign grant_data_d = d_req_i && (!f_req_i || !rr_q);
`else
  assign grant_data_d = d_req_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
      rdata_q  <= '0;
      f_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_q     <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          f_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          if (f_req_i || d_req_i) begin
            owner_q  <= grant_data_d;
            addr_q   <= grant_data_d ? d_addr_i : f_addr_i;
            if (grant_data_d) wd_q <= d_wd_i;
            we_q     <= grant_data_d && d_we_i;
            mem_we_q <= grant_data_d && d_we_i;
            mem_re_q <= !(grant_data_d && d_we_i);
`ifdef MEM_ARB_RR_EN
            rr_q     <= grant_data_d;
`endif
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          if (!we_q) rdata_q <= mem_rd_i;
          f_ack_q  <= !owner_q;
          d_ack_q  <= owner_q;
          state_q  <= RESP;
        end
        RESP: begin
          f_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          f_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign f_ack_o    = f_ack_q;
  assign d_ack_o    = d_ack_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = (state_q != IDLE);
  assign owner_o    = owner_q;
  assign mem_addr_o = addr_q;
  assign mem_wd_o   = wd_q;
  assign mem_we_o   = mem_we_q;
  assign mem_re_o   = mem_re_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wd = '0;
  logic        d_ack;
  logic [31:0] rdata;
  logic        busy;
  logic        owner;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  tie_exp;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_ack_o(f_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wd_i(d_wd), .d_ack_o(d_ack),
    .rdata_o(rdata), .busy_o(busy), .owner_o(owner),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_re_o(mem_re),
    .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) ^ 32'hA5A5_0000;
    mem[8'h04] = 32'h0050_0093;
    mem[8'h20] = 32'h2222_2222;
    mem[8'h30] = 32'h1111_1111;
`ifdef MEM_ARB_RR_EN
    tie_exp = 4'b1010;
`else
    tie_exp = 4'b1111;
`endif

    // Reset values
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_f_ack", 32'(f_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // Fetch read
    f_req = 1'b1; f_addr = 32'h4;
    tick();
    check("fetch_mem_re", 32'(mem_re), 32'd1);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    check("fetch_mem_addr", mem_addr, 32'h4);
    check("fetch_busy", 32'(busy), 32'd1);
    tick();
    check("fetch_f_ack", 32'(f_ack), 32'd1);
    check("fetch_d_ack", 32'(d_ack), 32'd0);
    check("fetch_rdata", rdata, 32'h0050_0093);
    check("fetch_owner", 32'(owner), 32'd0);
    check("fetch_re_off", 32'(mem_re), 32'd0);
    f_req = 1'b0;
    tick();
    check("fetch_idle_busy", 32'(busy), 32'd0);
    check("fetch_ack_pulse", 32'(f_ack), 32'd0);

    // Store 0xDEADBEEF to 0x10
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wd = 32'hDEAD_BEEF;
    tick();
    check("store_mem_we", 32'(mem_we), 32'd1);
    check("store_mem_re", 32'(mem_re), 32'd0);
    check("store_mem_wd", mem_wd, 32'hDEAD_BEEF);
    tick();
    check("store_d_ack", 32'(d_ack), 32'd1);
    check("store_we_off", 32'(mem_we), 32'd0);
    check("store_mem", mem[8'h10], 32'hDEAD_BEEF);
    check("store_rdata_hold", rdata, 32'h0050_0093);
    check("store_owner", 32'(owner), 32'd1);
    d_req = 1'b0;
    tick();

    // Load 0x10, with d_addr changed to 0x20 while the access is in flight
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    tick();
    d_addr = 32'h20; d_we = 1'b1;
    #2;
    check("load_mem_addr_latched", mem_addr, 32'h10);
    check("load_mem_re", 32'(mem_re), 32'd1);
    check("load_mem_we", 32'(mem_we), 32'd0);
    tick();
    check("load_d_ack", 32'(d_ack), 32'd1);
    check("load_rdata", rdata, 32'hDEAD_BEEF);
    check("load_mem20_untouched", mem[8'h20], 32'h2222_2222);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Tie: both requesters held, each re-requesting after its ack
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 32'h4; d_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      while (!(f_ack || d_ack) && w < 10) begin
        tick();
        w++;
      end
      check($sformatf("tie%0d_ack", k), 32'(f_ack || d_ack), 32'd1);
      check($sformatf("tie%0d_owner", k), 32'(d_ack), 32'(tie_exp[k]));
      if (d_ack) d_req = 1'b0;
      else f_req = 1'b0;
      tick();
      f_req = 1'b1; d_req = 1'b1;
    end
    f_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();
    check("tie_done_busy", 32'(busy), 32'd0);

    // Reset during a store ACCESS aborts the write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wd = 32'hCAFE_F00D;
    tick();
    check("abort_mem_we_before", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_we_async", 32'(mem_we), 32'd0);
    check("abort_busy_async", 32'(busy), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("abort_mem30", mem[8'h30], 32'h1111_1111);
    check("abort_no_d_ack", 32'(d_ack), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_no_late_ack", 32'(d_ack), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
